// File: rtl/sprite_pkg.sv
// Shared widths, defaults and packed-bus slice helpers for the sprite overlay stage.
package sprite_pkg;

    localparam int unsigned COLOR_W      = 24;
    localparam int unsigned X_W          = 10;
    localparam int unsigned Y_W          = 9;
    localparam int unsigned SPRITE_W_DEF = 25;
    localparam int unsigned SPRITE_H_DEF = 25;

    localparam logic [COLOR_W-1:0] WALL_COLOR = 24'hFF5757;
    localparam logic [COLOR_W-1:0] BLACK      = 24'h000000;

    function automatic int unsigned xLsb(input int unsigned ch);
        return ch * X_W;
    endfunction

    function automatic int unsigned yLsb(input int unsigned ch);
        return ch * Y_W;
    endfunction

    function automatic int unsigned colorLsb(input int unsigned ch);
        return ch * COLOR_W;
    endfunction

endpackage

// File: rtl/sprite_compositor_if.sv
// Pixel stream, packed sprite attributes and collision results of the compositor.
interface sprite_compositor_if
    import sprite_pkg::*;
#(
    parameter int unsigned NUM_SPRITES = 4
);

    logic                           iVS;
    logic                           iBLANK_n;
    logic [COLOR_W-1:0]             iBG;
    logic [X_W*NUM_SPRITES-1:0]     iSprX;
    logic [Y_W*NUM_SPRITES-1:0]     iSprY;
    logic [NUM_SPRITES-1:0]         iSprEn;
    logic [COLOR_W*NUM_SPRITES-1:0] iSprColor;
    logic                           iBlackout;

    logic [COLOR_W-1:0]             oBGR;
    logic                           oBLANK_n;
    logic [NUM_SPRITES-1:0]         oWall;
    logic [NUM_SPRITES-1:0]         oOverlap;
    logic                           oCollValid;

    modport master (
        output iVS, iBLANK_n, iBG, iSprX, iSprY, iSprEn, iSprColor, iBlackout,
        input  oBGR, oBLANK_n, oWall, oOverlap, oCollValid
    );

    modport slave (
        input  iVS, iBLANK_n, iBG, iSprX, iSprY, iSprEn, iSprColor, iBlackout,
        output oBGR, oBLANK_n, oWall, oOverlap, oCollValid
    );

endinterface

// File: rtl/sprite_hit.sv
// One sprite channel: frame-latched position/enable and the rectangle hit test.
module sprite_hit
    import sprite_pkg::*;
#(
    parameter int unsigned SPRITE_W = SPRITE_W_DEF,
    parameter int unsigned SPRITE_H = SPRITE_H_DEF
) (
    input  logic           iVGA_CLK,
    input  logic           iRST_n,
    input  logic           iLoad,
    input  logic [X_W-1:0] iSprX,
    input  logic [Y_W-1:0] iSprY,
    input  logic           iSprEn,
    input  logic [X_W-1:0] iX,
    input  logic [Y_W-1:0] iY,
    output logic           oHit
);

    logic [X_W-1:0] sxQ;
    logic [Y_W-1:0] syQ;
    logic           enQ;
    logic [X_W:0]   xEnd;
    logic [Y_W:0]   yEnd;

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            sxQ <= '0;
            syQ <= '0;
            enQ <= 1'b0;
        end else if (iLoad) begin
            sxQ <= iSprX;
            syQ <= iSprY;
            enQ <= iSprEn;
        end
    end

    // One extra bit on the far edge so sprites clip at the screen edge instead of wrapping.
    always_comb begin
        xEnd = {1'b0, sxQ} + (X_W+1)'(SPRITE_W);
        yEnd = {1'b0, syQ} + (Y_W+1)'(SPRITE_H);
        oHit = enQ && (iX >= sxQ) && ({1'b0, iX} < xEnd) && (iY >= syQ) && ({1'b0, iY} < yEnd);
    end

endmodule

// File: rtl/sprite_compositor.sv
// Sprite overlay stage: fixed-priority solid sprites over the background, two-cycle
// pipeline, with per-frame wall-contact and overlap flags published after the last pixel.
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int unsigned        NUM_SPRITES = 4,
    parameter int unsigned        H_ACTIVE    = 640,
    parameter int unsigned        V_ACTIVE    = 480,
    parameter int unsigned        SPRITE_W    = sprite_pkg::SPRITE_W_DEF,
    parameter int unsigned        SPRITE_H    = sprite_pkg::SPRITE_H_DEF,
    parameter logic [COLOR_W-1:0] WALL_COLOR  = sprite_pkg::WALL_COLOR
) (
    input logic                iVGA_CLK,
    input logic                iRST_n,
    sprite_compositor_if.slave bus
);

    logic                   frameStart;
    logic [X_W-1:0]         xQ, xD;
    logic [Y_W-1:0]         yQ, yD;
    logic [NUM_SPRITES-1:0] hit;

    logic [COLOR_W-1:0]     colorQ [NUM_SPRITES];
    logic                   blackoutQ;
    logic                   frameValidQ;

    logic [NUM_SPRITES-1:0] hitQ;
    logic [COLOR_W-1:0]     bgQ;
    logic                   blankQ;
    logic                   lastQ;

    logic [COLOR_W-1:0]     pixColor;
    logic [3:0]             nHits;
    logic [NUM_SPRITES-1:0] wallTerm, ovlTerm;
    logic [NUM_SPRITES-1:0] wallAccQ, ovlAccQ, wallQ, ovlQ;
    logic [COLOR_W-1:0]     bgrQ;
    logic                   blankOutQ, collValidQ;

    assign frameStart = ~bus.iVS;

    always_comb begin
        xD = xQ;
        yD = yQ;
        if (frameStart) begin
            xD = '0;
            yD = '0;
        end else if (bus.iBLANK_n) begin
            if (xQ == X_W'(H_ACTIVE - 1)) begin
                xD = '0;
                yD = (yQ == Y_W'(V_ACTIVE - 1)) ? '0 : yQ + 1'b1;
            end else begin
                xD = xQ + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_SPRITES; i++) begin : gHit
        sprite_hit #(
            .SPRITE_W (SPRITE_W),
            .SPRITE_H (SPRITE_H)
        ) uHit (
            .iVGA_CLK (iVGA_CLK),
            .iRST_n   (iRST_n),
            .iLoad    (frameStart),
            .iSprX    (bus.iSprX[xLsb(i) +: X_W]),
            .iSprY    (bus.iSprY[yLsb(i) +: Y_W]),
            .iSprEn   (bus.iSprEn[i]),
            .iX       (xQ),
            .iY       (yQ),
            .oHit     (hit[i])
        );
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            xQ          <= '0;
            yQ          <= '0;
            blackoutQ   <= 1'b0;
            frameValidQ <= 1'b0;
            for (int i = 0; i < NUM_SPRITES; i++) colorQ[i] <= '0;
            hitQ        <= '0;
            bgQ         <= '0;
            blankQ      <= 1'b0;
            lastQ       <= 1'b0;
        end else begin
            xQ <= xD;
            yQ <= yD;
            if (frameStart) begin
                blackoutQ   <= bus.iBlackout;
                frameValidQ <= 1'b1;
                for (int i = 0; i < NUM_SPRITES; i++) begin
                    colorQ[i] <= bus.iSprColor[colorLsb(i) +: COLOR_W];
                end
            end
            hitQ   <= hit;
            bgQ    <= bus.iBG;
            blankQ <= bus.iBLANK_n;
            // Only a frame that began with iVS=0 may publish.
            lastQ  <= bus.iBLANK_n && bus.iVS && frameValidQ &&
                      (xQ == X_W'(H_ACTIVE - 1)) && (yQ == Y_W'(V_ACTIVE - 1));
        end
    end

    always_comb begin
        pixColor = blackoutQ ? BLACK : bgQ;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hitQ[i]) pixColor = colorQ[i];
        end
        if (!blankQ) pixColor = BLACK;

        nHits = '0;
        for (int i = 0; i < NUM_SPRITES; i++) nHits = nHits + 4'(hitQ[i]);

        wallTerm = (blankQ && (bgQ == WALL_COLOR)) ? hitQ : '0;
        ovlTerm  = (blankQ && (nHits >= 4'd2))     ? hitQ : '0;
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            wallAccQ   <= '0;
            ovlAccQ    <= '0;
            wallQ      <= '0;
            ovlQ       <= '0;
            bgrQ       <= '0;
            blankOutQ  <= 1'b0;
            collValidQ <= 1'b0;
        end else begin
            bgrQ      <= pixColor;
            blankOutQ <= blankQ;
            if (lastQ) begin
                wallQ      <= wallAccQ | wallTerm;
                ovlQ       <= ovlAccQ | ovlTerm;
                wallAccQ   <= '0;
                ovlAccQ    <= '0;
                collValidQ <= 1'b1;
            end else begin
                collValidQ <= 1'b0;
                if (frameStart) begin
                    wallAccQ <= '0;
                    ovlAccQ  <= '0;
                end else begin
                    wallAccQ <= wallAccQ | wallTerm;
                    ovlAccQ  <= ovlAccQ | ovlTerm;
                end
            end
        end
    end

    assign bus.oBGR       = bgrQ;
    assign bus.oBLANK_n   = blankOutQ;
    assign bus.oWall      = wallQ;
    assign bus.oOverlap   = ovlQ;
    assign bus.oCollValid = collValidQ;

endmodule

// File: tb/tb_sprite_compositor.sv
// Self-checking bench for sprite_compositor: frame-level reference model plus directed scenarios.
module tb_sprite_compositor;
    import sprite_pkg::*;

    localparam int NS = 4;
    localparam int HA = 640;
    localparam int VA = 8;
    localparam int SW = 25;
    localparam int SH = 3;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    sprite_compositor_if #(.NUM_SPRITES(NS)) bus ();

    sprite_compositor #(
        .NUM_SPRITES (NS),
        .H_ACTIVE    (HA),
        .V_ACTIVE    (VA),
        .SPRITE_W    (SW),
        .SPRITE_H    (SH),
        .WALL_COLOR  (WALL_COLOR)
    ) dut (
        .iVGA_CLK (clk),
        .iRST_n   (rstN),
        .bus      (bus)
    );

    typedef struct {
        logic [23:0]   bgr;
        logic          blank;
        logic          cv;
        logic [NS-1:0] wall;
        logic [NS-1:0] ovl;
        int            x;
        int            y;
    } exp_t;

    exp_t q[$];
    int nCmp = 0;
    int nFail = 0;
    int cvCount = 0;
    logic [23:0] seen [VA][HA];

    // Stimulus configuration (what the bench drives) and the model's frame-latched copy.
    int cfgX[NS], cfgY[NS];
    logic cfgEn[NS];
    logic [23:0] cfgCol[NS];
    logic cfgBlk;
    int shX[NS], shY[NS];
    logic shEn[NS];
    logic [23:0] shCol[NS];
    logic shBlk;

    int mx, my;
    logic mValid;
    logic [NS-1:0] accW, accO, pubW, pubO;

    task automatic apply_cfg();
        for (int i = 0; i < NS; i++) begin
            bus.iSprX[i*10 +: 10]     = 10'(cfgX[i]);
            bus.iSprY[i*9 +: 9]       = 9'(cfgY[i]);
            bus.iSprEn[i]             = cfgEn[i];
            bus.iSprColor[i*24 +: 24] = cfgCol[i];
        end
        bus.iBlackout = cfgBlk;
    endtask

    task automatic clear_cfg();
        for (int i = 0; i < NS; i++) begin
            cfgX[i] = 0; cfgY[i] = 0; cfgEn[i] = 1'b0; cfgCol[i] = '0;
        end
        cfgBlk = 1'b0;
    endtask

    task automatic model_reset();
        q.delete();
        mx = 0; my = 0; mValid = 1'b0;
        accW = '0; accO = '0; pubW = '0; pubO = '0;
        for (int i = 0; i < NS; i++) begin
            shX[i] = 0; shY[i] = 0; shEn[i] = 1'b0; shCol[i] = '0;
        end
        shBlk = 1'b0;
    endtask

    // Drive one input cycle, predict its output, and check the output due now.
    task automatic cycle(input logic vs, input logic blank, input logic [23:0] bg);
        exp_t e, o;
        logic [NS-1:0] hv;
        int first;
        int nh;
        bus.iVS = vs;
        bus.iBLANK_n = blank;
        bus.iBG = bg;
        e.bgr = '0; e.blank = 1'b0; e.cv = 1'b0; e.x = -1; e.y = -1;
        if (!vs) begin
            for (int i = 0; i < NS; i++) begin
                shX[i] = cfgX[i]; shY[i] = cfgY[i]; shEn[i] = cfgEn[i]; shCol[i] = cfgCol[i];
            end
            shBlk = cfgBlk;
            mx = 0; my = 0; accW = '0; accO = '0; mValid = 1'b1;
        end else if (blank) begin
            hv = '0; first = -1; nh = 0;
            for (int i = 0; i < NS; i++) begin
                if (shEn[i] && mx >= shX[i] && mx < shX[i] + SW && my >= shY[i] && my < shY[i] + SH) begin
                    hv[i] = 1'b1;
                    nh++;
                    if (first < 0) first = i;
                end
            end
            e.blank = 1'b1;
            e.bgr = (first >= 0) ? shCol[first] : (shBlk ? 24'h0 : bg);
            if (bg == WALL_COLOR) accW = accW | hv;
            if (nh >= 2) accO = accO | hv;
            e.x = mx; e.y = my;
            if (mx == HA - 1 && my == VA - 1 && mValid) begin
                pubW = accW; pubO = accO; accW = '0; accO = '0; e.cv = 1'b1;
            end
            if (mx == HA - 1) begin
                mx = 0;
                my = (my == VA - 1) ? 0 : my + 1;
            end else begin
                mx++;
            end
        end
        e.wall = pubW;
        e.ovl = pubO;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (bus.oCollValid) cvCount++;
        if (q.size() >= 2) begin
            o = q.pop_front();
            nCmp++;
            if ({bus.oBGR, bus.oBLANK_n, bus.oCollValid, bus.oWall, bus.oOverlap} !==
                {o.bgr, o.blank, o.cv, o.wall, o.ovl}) begin
                nFail++;
                $display("FAIL stream px(%0d,%0d) got bgr=%h bl=%b cv=%b w=%b o=%b want bgr=%h bl=%b cv=%b w=%b o=%b",
                         o.x, o.y, bus.oBGR, bus.oBLANK_n, bus.oCollValid, bus.oWall, bus.oOverlap,
                         o.bgr, o.blank, o.cv, o.wall, o.ovl);
            end
            if (o.x >= 0) seen[o.y][o.x] = bus.oBGR;
        end
    endtask

    function automatic logic [23:0] bg_at(input int mode, input int x, input int y);
        if (mode == 1) return (x == 300 && y == 4) ? WALL_COLOR : 24'h123456;
        if (mode == 2) return ($urandom_range(7) == 0) ? WALL_COLOR : 24'($urandom);
        return 24'h123456;
    endfunction

    task automatic run_frame(input int mode, input int chgAt, input int chgX);
        cycle(1'b1, 1'b0, '0); cycle(1'b1, 1'b0, '0); cycle(1'b1, 1'b0, '0);
        cycle(1'b0, 1'b0, '0); cycle(1'b1, 1'b0, '0); cycle(1'b1, 1'b0, '0);
        for (int y = 0; y < VA; y++) begin
            for (int x = 0; x < HA; x++) begin
                if ($urandom_range(15) == 0) cycle(1'b1, 1'b0, 24'($urandom));
                if (y * HA + x == chgAt) begin
                    cfgX[0] = chgX;
                    apply_cfg();
                end
                cycle(1'b1, 1'b1, bg_at(mode, x, y));
            end
        end
        repeat (4) cycle(1'b1, 1'b0, '0);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        nCmp++;
        if (got !== want) begin
            nFail++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_bgr", 32'(bus.oBGR), 32'h0);
        chk("reset_blank", 32'(bus.oBLANK_n), 32'h0);
        chk("reset_wall", 32'(bus.oWall), 32'h0);
        chk("reset_ovl", 32'(bus.oOverlap), 32'h0);
        chk("reset_cv", 32'(bus.oCollValid), 32'h0);
        rstN = 1'b1;
        model_reset();
    endtask

    task automatic test_priority_overlap();
        clear_cfg();
        cfgEn[0] = 1'b1; cfgX[0] = 100; cfgY[0] = 2; cfgCol[0] = 24'h0000FF;
        cfgEn[2] = 1'b1; cfgX[2] = 110; cfgY[2] = 3; cfgCol[2] = 24'h00FF00;
        apply_cfg();
        cvCount = 0;
        run_frame(0, -1, 0);
        chk("basic_in", 32'(seen[2][100]), 32'h0000FF);
        chk("basic_left", 32'(seen[2][99]), 32'h123456);
        chk("basic_right", 32'(seen[2][125]), 32'h123456);
        chk("prio_low_wins", 32'(seen[3][110]), 32'h0000FF);
        chk("sprite2_only", 32'(seen[3][130]), 32'h00FF00);
        chk("ovl_pulses", 32'(cvCount), 32'd1);
        chk("ovl_flags", 32'(bus.oOverlap), 32'h5);
        chk("ovl_wall", 32'(bus.oWall), 32'h0);
    endtask

    task automatic test_wall_blackout();
        clear_cfg();
        cfgEn[1] = 1'b1; cfgX[1] = 290; cfgY[1] = 3; cfgCol[1] = 24'hABCDEF;
        cfgBlk = 1'b1;
        apply_cfg();
        cvCount = 0;
        run_frame(1, -1, 0);
        chk("blk_corner", 32'(seen[0][0]), 32'h0);
        chk("blk_open", 32'(seen[4][320]), 32'h0);
        chk("blk_sprite", 32'(seen[4][300]), 32'hABCDEF);
        chk("wall_flags", 32'(bus.oWall), 32'h2);
        chk("wall_ovl", 32'(bus.oOverlap), 32'h0);
        chk("wall_pulses", 32'(cvCount), 32'd1);
    endtask

    task automatic test_reset_midframe();
        clear_cfg();
        cfgEn[0] = 1'b1; cfgX[0] = 0; cfgY[0] = 0; cfgCol[0] = 24'h0000FF;
        apply_cfg();
        cycle(1'b1, 1'b0, '0); cycle(1'b0, 1'b0, '0); cycle(1'b1, 1'b0, '0);
        for (int i = 0; i < 1000; i++) cycle(1'b1, 1'b1, 24'h123456);
        #3 rstN = 1'b0;
        #1;
        chk("async_rst_outputs",
            32'({bus.oBGR, bus.oBLANK_n, bus.oWall, bus.oOverlap, bus.oCollValid}), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rstN = 1'b1;
        model_reset();
        cvCount = 0;
        for (int i = 0; i < HA * VA; i++) cycle(1'b1, 1'b1, 24'h123456);
        chk("no_vs_no_publish", 32'(cvCount), 32'd0);
        cycle(1'b0, 1'b0, '0); cycle(1'b1, 1'b0, '0);
        for (int i = 0; i < 2000; i++) cycle(1'b1, 1'b1, 24'h123456);
        cycle(1'b1, 1'b0, '0); cycle(1'b0, 1'b0, '0);
        repeat (4) cycle(1'b1, 1'b0, '0);
        chk("early_vs_no_publish", 32'(cvCount), 32'd0);
    endtask

    task automatic test_right_edge();
        clear_cfg();
        cfgEn[0] = 1'b1; cfgX[0] = 630; cfgY[0] = 6; cfgCol[0] = 24'h0000FF;
        apply_cfg();
        run_frame(0, -1, 0);
        chk("edge_first", 32'(seen[6][630]), 32'h0000FF);
        chk("edge_last", 32'(seen[6][639]), 32'h0000FF);
        chk("edge_bottom", 32'(seen[7][639]), 32'h0000FF);
        chk("edge_no_wrap", 32'(seen[7][0]), 32'h123456);
        chk("edge_before", 32'(seen[6][629]), 32'h123456);
    endtask

    task automatic test_midframe_update();
        clear_cfg();
        cfgEn[0] = 1'b1; cfgX[0] = 100; cfgY[0] = 2; cfgCol[0] = 24'h0000FF;
        apply_cfg();
        run_frame(0, HA, 200);
        chk("mid_old_pos", 32'(seen[2][100]), 32'h0000FF);
        chk("mid_new_hidden", 32'(seen[2][200]), 32'h123456);
        run_frame(0, -1, 0);
        chk("next_new_pos", 32'(seen[2][200]), 32'h0000FF);
        chk("next_old_gone", 32'(seen[2][100]), 32'h123456);
    endtask

    task automatic test_random();
        int bx, by;
        cvCount = 0;
        for (int f = 0; f < 3; f++) begin
            bx = $urandom_range(639);
            by = $urandom_range(VA - 1);
            for (int i = 0; i < NS; i++) begin
                cfgEn[i] = ($urandom_range(3) != 0);
                cfgX[i] = bx + $urandom_range(30);
                cfgY[i] = by + $urandom_range(2);
                cfgCol[i] = 24'($urandom);
            end
            cfgBlk = ($urandom_range(3) == 0);
            apply_cfg();
            run_frame(2, -1, 0);
        end
        chk("random_pulses", 32'(cvCount), 32'd3);
    endtask

    initial begin
        bus.iVS = 1'b1;
        bus.iBLANK_n = 1'b0;
        bus.iBG = '0;
        clear_cfg();
        apply_cfg();
        test_reset();
        test_priority_overlap();
        test_wall_blackout();
        test_reset_midframe();
        test_right_edge();
        test_midframe_update();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

Parametrised sprite overlay stage between the background pixel pipeline and the VGA output registers. It composites NUM_SPRITES rectangular, solid-colour sprites over the background stream with fixed index priority. Sprite state is double-buffered per frame, so updates never tear. It also accumulates per-sprite wall-contact and sprite-overlap flags over each frame and publishes them once per frame to the processor side.

## Interface
Parameters:
- NUM_SPRITES, 4, number of sprite channels (1..8)
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- SPRITE_W, 25, sprite width in pixels (all channels)
- SPRITE_H, 25, sprite height in lines (all channels)
- WALL_COLOR, 24'hFF5757, background colour treated as wall

Ports (one clock; reset is asynchronous and active-low):
- iVGA_CLK  in  1  pixel clock; all logic on rising edge
- iRST_n  in  1  asynchronous active-low reset
- iVS  in  1  active-low vertical sync; low = frame start
- iBLANK_n  in  1  high = iBG is an active pixel
- iBG  in  24  background BGR for the current active pixel, aligned with iBLANK_n
- iSprX  in  10*NUM_SPRITES  packed sprite left x, channel i at [10i+9:10i]
- iSprY  in  9*NUM_SPRITES  packed sprite top y
- iSprEn  in  NUM_SPRITES  per-channel enable
- iSprColor  in  24*NUM_SPRITES  per-channel BGR
- iBlackout  in  1  replace background with black
- oBGR  out  24  composited pixel
- oBLANK_n  out  1  iBLANK_n delayed to match oBGR
- oWall  out  NUM_SPRITES  sprite touched WALL_COLOR last frame
- oOverlap  out  NUM_SPRITES  sprite overlapped another sprite last frame
- oCollValid  out  1  one-cycle pulse when oWall/oOverlap update

## Operation
- Pixel counters x (10b), y (9b) advance on each cycle with iBLANK_n=1. At x=H_ACTIVE-1, x wraps to 0 and y increments. At y=V_ACTIVE-1 with x=H_ACTIVE-1, both wrap to 0.
- Frame start (iVS=0): x,y <= 0; the shadow registers load iSprX/Y/En/Color and iBlackout; accumulators clear without publishing. iVS=0 takes precedence over iBLANK_n=1 in the same cycle.
- Hit rule for channel i: shadow En[i] and sx<=x<sx+SPRITE_W and sy<=y<sy+SPRITE_H. Bounds are computed at 11/10 bits so sprites near the right or bottom edge clip instead of wrapping.
- Stage 1 registers the hit vector, iBG and iBLANK_n.
- Stage 2 output:
  - If any hit: colour of the lowest-index hit.
  - Else if shadow blackout: 0.
  - Else: background.
  - If blank (oBLANK_n=0): oBGR=0.
- Accumulators are updated from stage 1 (active pixels only):
  - wall[i] |= hit[i] && bg==WALL_COLOR. Wall detection uses the real background even during blackout.
  - overlap[i] |= hit[i] && popcount(hit)>=2.
- Publish: when stage 1 holds pixel (H_ACTIVE-1, V_ACTIVE-1), on the next edge oWall/oOverlap <= accumulated OR current-pixel terms, accumulators clear, and oCollValid=1 for exactly one cycle. Outputs hold until the next publish.

## Timing
- Latency iBG/iBLANK_n -> oBGR/oBLANK_n: 2 cycles, fixed, including across line and frame boundaries.
- Last active pixel in -> oCollValid high: 2 cycles.
- Sprite inputs are sampled only at frame start; changes mid-frame are invisible until the next iVS=0.
- Reset values: oBGR=0, oBLANK_n=0, oWall=0, oOverlap=0, oCollValid=0. x, y, pipeline, shadow registers (all sprites disabled, blackout off) and accumulators are all 0.
- Reset mid-frame: all state returns to reset values immediately. The first publish after reset requires a full frame following an iVS=0.
- A frame cut short by an early iVS=0 publishes nothing.

## Structure
- Package sprite_pkg holds: COLOR_W=24, X_W=10, Y_W=9, default SPRITE_W/SPRITE_H, WALL_COLOR and BLACK constants, and the channel-slice index helpers.
- Sub-module sprite_hit, one instance per channel: registered shadow x/y/en plus the hit comparator. The top level owns the counters, priority mux, accumulators and publish logic.

## Test plan
- Sprite 0 at (100,50), colour 24'h0000FF, flat background 24'h123456: pixel (100,50) -> 0000FF; (99,50) -> 123456; (125,50) -> 123456; output 2 cycles after input.
- Sprites 0 and 2 both covering (200,200): pixel shows sprite 0's colour; after the frame, oCollValid pulses once with oOverlap=4'b0101 and oWall=0.
- Sprite 1 over a single WALL_COLOR pixel, iBlackout=1: non-sprite pixels -> 0; at publish oWall=4'b0010.
- Sprite 0 at x=630: pixels 630..639 show the sprite, x=0 of the next line shows background (no wrap).
- iSprX[0] changed mid-frame: rendering is unchanged until the next iVS=0, then uses the new x.
- iRST_n low mid-frame: all outputs 0 asynchronously; an early iVS=0 frame produces no oCollValid pulse.
